// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed scan driver for a 4-digit common-anode 7-seg.
// Ports: clk, reset (async, high), en, dig0..dig3 (active-low patterns) in;
// seg (active-low bus), an (active-low anodes), frame_start out. All registered.
// Define SEG_SCAN_BLANK_EN to compile in BLANK_CYC dark clocks between digits.
module seg_scan_mux #(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] dig0,
  input  logic [6:0] dig1,
  input  logic [6:0] dig2,
  input  logic [6:0] dig3,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_start
);

`ifdef SEG_SCAN_BLANK_EN
  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;
  logic [7:0] blk_q, blk_d;
`else
  typedef enum logic [0:0] {IDLE, SHOW} state_t;
  logic [31:0] unused_blank_cyc;
  assign unused_blank_cyc = BLANK_CYC;
`endif

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [6:0]       snap_q [4];
  logic             snap_ld;
  logic [6:0]       seg_d;
  logic [3:0]       an_d;
  logic             fs_d;

  // Outputs are a registered decode of the current state, so the display
  // lags the state register by one clock and no input reaches an output
  // combinationally.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    snap_ld = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
    blk_d   = blk_q;
`endif
    seg_d   = 7'h7F;
    an_d    = 4'hF;
    fs_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = SHOW;
          idx_d   = 2'd0;
          pre_d   = '0;
          snap_ld = 1'b1;
        end
      end
      SHOW: begin
        seg_d = snap_q[idx_q];
        an_d  = ~(4'b0001 << idx_q);
        fs_d  = (idx_q == 2'd0) && (pre_q == '0);
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (pre_q == {DIV_W{1'b1}}) begin
`ifdef SEG_SCAN_BLANK_EN
          state_d = BLANK;
          blk_d   = 8'd0;
`else
          idx_d   = idx_q + 2'd1;
          pre_d   = '0;
          snap_ld = (idx_q == 2'd3);
`endif
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
`ifdef SEG_SCAN_BLANK_EN
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (blk_q == 8'(BLANK_CYC - 1)) begin
          state_d = SHOW;
          idx_d   = idx_q + 2'd1;
          pre_d   = '0;
          snap_ld = (idx_q == 2'd3);
        end else begin
          blk_d = blk_q + 8'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      pre_q       <= '0;
`ifdef SEG_SCAN_BLANK_EN
      blk_q       <= 8'd0;
`endif
      snap_q[0]   <= 7'h7F;
      snap_q[1]   <= 7'h7F;
      snap_q[2]   <= 7'h7F;
      snap_q[3]   <= 7'h7F;
      seg         <= 7'h7F;
      an          <= 4'hF;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pre_q       <= pre_d;
`ifdef SEG_SCAN_BLANK_EN
      blk_q       <= blk_d;
`endif
      if (snap_ld) begin
        snap_q[0] <= dig0;
        snap_q[1] <= dig1;
        snap_q[2] <= dig2;
        snap_q[3] <= dig3;
      end
      seg         <= seg_d;
      an          <= an_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Time-multiplexed scan driver for a four-digit common-anode 7-segment display. Sits directly downstream of the binary counter display stage: it takes the four per-digit segment patterns that stage produces and drives them onto one shared segment bus. It drives one active-low anode per digit, cycling through the digits fast enough for persistence of vision. All four patterns are snapshotted once per frame, so a counter update never tears a frame.

## Interface
- `DIV_W`, default 16: prescaler width; each digit dwells 2^DIV_W clocks.
- `BLANK_CYC`, default 4: blank (all-anodes-off) clocks between digits when blanking is compiled in; legal range 1..255.
- `clk` in 1: system clock; all state is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: scan enable, level-sensitive.
- `dig0` in 7: segment pattern for digit 0 (rightmost). Active-low, 1 = segment off.
- `dig1` in 7: segment pattern for digit 1.
- `dig2` in 7: segment pattern for digit 2.
- `dig3` in 7: segment pattern for digit 3 (leftmost).
- `seg` out 7: shared segment bus, active-low, registered.
- `an` out 4: digit anode selects, active-low, one-hot-low or all high, registered.
- `frame_start` out 1: one-clock pulse on the first clock digit 0 is displayed in each frame.

## Operation
- Reset values (asynchronous):
  - `seg`=7'h7F, `an`=4'hF, `frame_start`=0.
  - State IDLE, digit index 0, prescaler 0, blank counter 0, snapshot registers 7'h7F.
- States are IDLE, SHOW and BLANK (BLANK exists only with blanking compiled in).
- IDLE:
  - Outputs `an`=4'hF, `seg`=7'h7F.
  - If `en`=1, the next edge enters SHOW with index 0, loads the snapshot from `dig0`..`dig3` and pulses `frame_start`.
- SHOW:
  - `seg` = snapshot[index]; `an` has bit[index]=0 and all other bits 1.
  - Prescaler counts from 0 and wraps at 2^DIV_W−1. The terminal count is the dwell-end tick.
- Dwell end, blanking compiled in:
  - Go to BLANK. Outputs are `an`=4'hF and `seg`=7'h7F for BLANK_CYC clocks.
  - Then return to SHOW with index+1.
- Dwell end, blanking compiled out: go directly to SHOW with index+1.
- Index arithmetic is 2 bits, wrapping 3→0.
- Frame boundary (index wrapping 3→0):
  - The snapshot reloads from the current inputs.
  - `frame_start`=1 for exactly the first SHOW clock of digit 0.
- Prescaler clears to 0 on every entry to SHOW, so every digit gets exactly 2^DIV_W clocks.
- `en` falls in SHOW or BLANK: the next edge returns to IDLE with `an`=4'hF and index 0. The partial frame is abandoned.
- `en` re-rises: always restarts at digit 0 with a fresh snapshot.
- Inputs may change on any clock. Changes are visible only from the next frame's snapshot, never mid-frame.
- At most one `an` bit is low on any clock. `an`=4'hF whenever `seg`=7'h7F is due to blanking or IDLE.

## Timing
- `en` rising at edge N:
  - `an`=4'hE and `seg`=`dig0` (sampled at edge N) are valid after edge N+1.
  - `frame_start` is high during the same clock.
- Dwell per digit: 2^DIV_W clocks.
- Frame period: 4·(2^DIV_W + BLANK_CYC) clocks with blanking, 4·2^DIV_W without.
- `en` falling at edge N: `an`=4'hF after edge N+1.
- `reset` asserted: outputs take reset values immediately, with no clock needed. Deassertion is synchronized externally.
- No combinational path from any input to any output.

## Configuration
- Macro: `SEG_SCAN_BLANK_EN`.
- Defined: the BLANK state is compiled in, and BLANK_CYC dark clocks separate consecutive digits to suppress ghosting.
- Undefined: the BLANK state and blank counter are removed, the next digit follows its predecessor immediately, and BLANK_CYC is ignored.

## Test plan
All scenarios use DIV_W=2 (dwell 4) and BLANK_CYC=2.
- Reset: assert `reset` mid-SHOW with no clock edge → `an`=4'hF, `seg`=7'h7F, `frame_start`=0 immediately.
- Scan order, blanking on:
  - Stimulus: `dig0`..`dig3` = 7'h7E, 7'h3F, 7'h06, 7'h40; `en`=1.
  - Required `an` sequence: E×4, F×2, D×4, F×2, B×4, F×2, 7×4, F×2, then repeat.
  - `seg` matches each digit's pattern; `frame_start` pulses every 24 clocks.
- Scan order, blanking off: same stimulus → `an` E×4, D×4, B×4, 7×4, with a frame period of 16 clocks.
- Snapshot: change `dig0` to 7'h00 while digit 2 is showing → `seg` for digit 0 stays 7'h7E until the next frame. It then becomes 7'h00, coincident with `frame_start`.
- Enable drop:
  - Deassert `en` during digit 1 → `an`=4'hF one clock later.
  - Reassert `en` → `an`=4'hE one clock later, with a `frame_start` pulse.
- Exclusivity check: over 1000 random-input clocks with random `en` toggles, `an` is never other than 4'hF or one-hot-low.
